// File: rtl/snax_gemmx_d32_serializer.sv
// ---------------------------------------------------------------------------
// snax_gemmx_d32_serializer
//
// Splits one wide GEMM D32 result word into Ratio narrower beats for the
// writer streamer. Beat 0 carries the LSBs of the word. When the last beat is
// handed off, a new word can be captured in the same cycle, so there is no
// bubble between words.
//
// Optional feature macro: SNAX_GEMMX_SER_BEAT_CNT_EN
//   defined   -> 32-bit counter of completed output beats on beat_cnt_o,
//                with a synchronous clear on cnt_clr_i
//   undefined -> no counter flops, beat_cnt_o = 0, cnt_clr_i ignored
//
// Ports
//   clk_i        clock
//   rst_ni       asynchronous active-low reset
//   in_data_i    D32 result word (InWidth)
//   in_valid_i   word valid
//   in_ready_o   word accepted when high together with in_valid_i
//   out_data_o   current beat (OutWidth)
//   out_valid_o  beat valid
//   out_ready_i  downstream ready
//   busy_o       high while a word is held
//   cnt_clr_i    synchronous clear of the beat counter
//   beat_cnt_o   completed output beats
//
// state | meaning
// ------+--------------------------------------------------------------
// EMPTY | no word held, ready to capture a new word
// FULL  | word held, presenting beat idx; last-beat handoff may refill
// ---------------------------------------------------------------------------
module snax_gemmx_d32_serializer #(
    parameter int unsigned InWidth  = 2048,
    parameter int unsigned OutWidth = 512
) (
    input  logic                clk_i,
    input  logic                rst_ni,
    input  logic [InWidth-1:0]  in_data_i,
    input  logic                in_valid_i,
    output logic                in_ready_o,
    output logic [OutWidth-1:0] out_data_o,
    output logic                out_valid_o,
    input  logic                out_ready_i,
    output logic                busy_o,
    input  logic                cnt_clr_i,
    output logic [31:0]         beat_cnt_o
);

    localparam int unsigned Ratio = InWidth / OutWidth;
    localparam int unsigned IdxW  = (Ratio > 1) ? $clog2(Ratio) : 1;

    if ((InWidth % OutWidth) != 0 || Ratio < 2) begin : gen_param_check
        $error("snax_gemmx_d32_serializer: InWidth must be an integer multiple (>=2) of OutWidth");
    end

    typedef enum logic {
        EMPTY = 1'b0,
        FULL  = 1'b1
    } state_e;

    state_e                          state_q, state_d;
    logic [InWidth-1:0]              data_q;
    logic [IdxW-1:0]                 idx_q;
    logic [Ratio-1:0][OutWidth-1:0]  beats;
    logic                            last_beat;
    logic                            in_fire;
    logic                            out_fire;

    assign last_beat = (idx_q == IdxW'(Ratio - 1));
    assign in_fire   = in_valid_i & in_ready_o;
    assign out_fire  = out_valid_o & out_ready_i;

    // State register
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= EMPTY;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            EMPTY: begin
                if (in_valid_i) state_d = FULL;
            end
            FULL: begin
                if (out_ready_i && last_beat) state_d = in_valid_i ? FULL : EMPTY;
            end
            default: state_d = EMPTY;
        endcase
    end

    // Output logic; in_ready_o is a function of state, idx and out_ready_i
    // only, so the upstream valid can never loop back into its own ready.
    always_comb begin
        in_ready_o  = 1'b0;
        out_valid_o = 1'b0;
        busy_o      = 1'b0;
        case (state_q)
            EMPTY: begin
                in_ready_o = 1'b1;
            end
            FULL: begin
                out_valid_o = 1'b1;
                busy_o      = 1'b1;
                in_ready_o  = out_ready_i & last_beat;
            end
            default: ;
        endcase
    end

    // Held word and beat index. A capture always restarts at beat 0; it takes
    // priority over the index increment on the refill cycle.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            data_q <= '0;
            idx_q  <= '0;
        end else if (in_fire) begin
            data_q <= in_data_i;
            idx_q  <= '0;
        end else if (out_fire) begin
            idx_q  <= idx_q + 1'b1;
        end
    end

    assign beats      = data_q;
    assign out_data_o = beats[idx_q];

`ifdef SNAX_GEMMX_SER_BEAT_CNT_EN
    logic [31:0] beat_cnt_q;

    // Clear wins over a simultaneous handshake; natural 32-bit wrap.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            beat_cnt_q <= '0;
        end else if (cnt_clr_i) begin
            beat_cnt_q <= '0;
        end else if (out_fire) begin
            beat_cnt_q <= beat_cnt_q + 32'd1;
        end
    end

    assign beat_cnt_o = beat_cnt_q;
`else
    logic unused_cnt_clr;

    assign unused_cnt_clr = cnt_clr_i;
    assign beat_cnt_o     = '0;
`endif

endmodule

// File: tb/tb_snax_gemmx_d32_serializer.sv
module tb_snax_gemmx_d32_serializer;

    localparam int IW = 2048;
    localparam int OW = 512;
    localparam int R  = IW / OW;

    logic          clk;
    logic          rst_n;
    logic [IW-1:0] in_data;
    logic          in_valid;
    logic          in_ready;
    logic [OW-1:0] out_data;
    logic          out_valid;
    logic          out_ready;
    logic          busy;
    logic          cnt_clr;
    logic [31:0]   beat_cnt;

    int vectors    = 0;
    int miscompares = 0;

    typedef struct {
        logic [OW-1:0] data;
        int            idx;
    } beat_t;

    beat_t       sb[$];
    logic [31:0] cnt_m = 32'd0;

    snax_gemmx_d32_serializer #(
        .InWidth  (IW),
        .OutWidth (OW)
    ) dut (
        .clk_i       (clk),
        .rst_ni      (rst_n),
        .in_data_i   (in_data),
        .in_valid_i  (in_valid),
        .in_ready_o  (in_ready),
        .out_data_o  (out_data),
        .out_valid_o (out_valid),
        .out_ready_i (out_ready),
        .busy_o      (busy),
        .cnt_clr_i   (cnt_clr),
        .beat_cnt_o  (beat_cnt)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk_bit(input string name, input logic act, input logic exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
        end
    endtask

    task automatic chk32(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic chk_data(input logic [OW-1:0] act, input logic [OW-1:0] exp, input int idx);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL out_data beat %0d: got %0h expected %0h at %0t", idx, act, exp, $time);
        end
    endtask

    // Reference model: an accepted word becomes R beats, LSB slice first;
    // a word is held exactly while beats of it remain outstanding.
    always @(negedge clk) begin
        if (!rst_n) begin
            chk_bit("rst out_valid", out_valid, 1'b0);
            chk_bit("rst in_ready", in_ready, 1'b1);
            chk_bit("rst busy", busy, 1'b0);
            chk32("rst beat_cnt", beat_cnt, 32'd0);
            sb.delete();
            cnt_m = 32'd0;
        end else begin
            logic exp_v, exp_rdy, fire;
            exp_v   = (sb.size() != 0);
            exp_rdy = !exp_v || (out_ready && sb[0].idx == R - 1);
            chk_bit("out_valid", out_valid, exp_v);
            chk_bit("busy", busy, exp_v);
            chk_bit("in_ready", in_ready, exp_rdy);
            if (exp_v && out_valid) chk_data(out_data, sb[0].data, sb[0].idx);
`ifdef SNAX_GEMMX_SER_BEAT_CNT_EN
            chk32("beat_cnt", beat_cnt, cnt_m);
`else
            chk32("beat_cnt", beat_cnt, 32'd0);
`endif
            fire = out_valid && out_ready;
            if (fire && exp_v) void'(sb.pop_front());
            if (cnt_clr) cnt_m = 32'd0;
            else if (fire) cnt_m = cnt_m + 32'd1;
            if (in_valid && in_ready) begin
                for (int k = 0; k < R; k++) begin
                    beat_t         b;
                    logic [IW-1:0] sh;
                    sh     = in_data >> (k * OW);
                    b.data = sh[OW-1:0];
                    b.idx  = k;
                    sb.push_back(b);
                end
            end
        end
    end

    function automatic logic [IW-1:0] rand_word();
        logic [IW-1:0] w;
        for (int i = 0; i < IW / 32; i++) w[i*32 +: 32] = $urandom();
        return w;
    endfunction

    function automatic logic [IW-1:0] pattern_word();
        logic [IW-1:0] w;
        for (int k = 0; k < R; k++)
            for (int b = 0; b < OW / 8; b++) w[k*OW + b*8 +: 8] = 8'(k);
        return w;
    endfunction

    // Present a word and hold it until accepted; returns just after the
    // accepting edge with in_valid still high.
    task automatic send(input logic [IW-1:0] w);
        bit ok;
        ok       = 1'b0;
        in_data  = w;
        in_valid = 1'b1;
        for (int n = 0; n < 200; n++) begin
            @(negedge clk);
            if (in_ready) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) begin
            miscompares++;
            $display("FAIL send timeout: in_ready stayed 0, expected 1 within 200 cycles");
        end
        @(posedge clk);
        #1;
    endtask

    task automatic drain();
        bit ok;
        ok        = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        for (int n = 0; n < 50; n++) begin
            @(negedge clk);
            if (!out_valid) begin
                ok = 1'b1;
                break;
            end
        end
        vectors++;
        if (!ok) begin
            miscompares++;
            $display("FAIL drain timeout: out_valid stayed 1, expected 0 within 50 cycles");
        end
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    initial begin
        bit acc;
        rst_n     = 1'b0;
        in_data   = '0;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        cnt_clr   = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b1;

        // Single pattern word, free-flowing downstream
        out_ready = 1'b1;
        send(pattern_word());
        in_valid = 1'b0;
        drain();

        // Back-to-back words, no bubble
        send(rand_word());
        send(rand_word());
        in_valid = 1'b0;
        drain();

        // Backpressure while beat 2 is presented
        out_ready = 1'b0;
        send(pattern_word());
        in_valid  = 1'b0;
        out_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        out_ready = 1'b0;
        repeat (5) @(posedge clk);
        #1;
        chk32("frozen beat 2 lane", 32'(out_data[7:0]), 32'd2);
        drain();

        // Reset in the middle of a word
        send(rand_word());
        in_valid = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        chk_bit("async reset out_valid", out_valid, 1'b0);
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        send(pattern_word());
        in_valid = 1'b0;
        drain();

        // Beat counter: three words from a clean start
        do_reset();
        for (int i = 0; i < 3; i++) send(rand_word());
        in_valid = 1'b0;
        drain();
        @(negedge clk);
`ifdef SNAX_GEMMX_SER_BEAT_CNT_EN
        chk32("beat_cnt after 3 words", beat_cnt, 32'd12);
`else
        chk32("beat_cnt without counter", beat_cnt, 32'd0);
`endif
        @(posedge clk);
        #1;

        // Clear on a handshake cycle
        send(rand_word());
        in_valid = 1'b0;
        cnt_clr  = 1'b1;
        @(posedge clk);
        #1;
        cnt_clr = 1'b0;
        drain();

`ifdef SNAX_GEMMX_SER_BEAT_CNT_EN
        // Wrap from near all-ones
        dut.beat_cnt_q = 32'hFFFF_FFFE;
        cnt_m          = 32'hFFFF_FFFE;
        send(rand_word());
        in_valid = 1'b0;
        drain();
        @(negedge clk);
        chk32("beat_cnt wrap", beat_cnt, 32'd2);
        @(posedge clk);
        #1;
`endif

        // Randomized traffic with random backpressure and rare clears
        for (int c = 0; c < 3000; c++) begin
            @(negedge clk);
            acc = in_valid && in_ready;
            @(posedge clk);
            #1;
            if (!in_valid || acc) begin
                in_valid = ($urandom_range(0, 2) != 0);
                if (in_valid) in_data = rand_word();
            end
            out_ready = ($urandom_range(0, 3) != 0);
            cnt_clr   = ($urandom_range(0, 31) == 0);
        end
        cnt_clr = 1'b0;
        drain();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/snax_gemmx_d32_serializer.md
SNAX_GEMMX_D32_SERIALIZER -- requirements
Module: snax_gemmx_d32_serializer

Interface
REQ-001 SHALL have parameter InWidth, default 2048, width of the GEMM D32 result word consumed.
REQ-002 SHALL have parameter OutWidth, default 512, width of each beat produced toward the writer streamer.
REQ-003 SHALL have localparam Ratio = InWidth/OutWidth (default 4); InWidth not an integer multiple of OutWidth, or Ratio < 2, SHALL be an elaboration error.
REQ-004 SHALL have one clock and an asynchronous active-low reset: clk_i  input  1  clock; rst_ni  input  1  reset, asynchronous, active low.
REQ-005 in_data_i  input  InWidth  D32 result word from accelerator.
REQ-006 in_valid_i  input  1  word valid.
REQ-007 in_ready_o  output  1  word accepted when high with in_valid_i.
REQ-008 out_data_o  output  OutWidth  current beat.
REQ-009 out_valid_o  output  1  beat valid.
REQ-010 out_ready_i  input  1  downstream ready.
REQ-011 busy_o  output  1  high while a word is held.
REQ-012 cnt_clr_i  input  1  synchronous clear of beat counter.
REQ-013 beat_cnt_o  output  32  completed output beats.

Function
REQ-014 SHALL hold one InWidth word in a register plus a beat index idx of ceil(log2(Ratio)) bits; two states: EMPTY, FULL.
REQ-015 EMPTY: in_ready_o=1, out_valid_o=0; in_valid_i -> capture in_data_i, idx=0, go FULL next cycle.
REQ-016 FULL: out_valid_o=1, out_data_o = held word bits [idx*OutWidth +: OutWidth] (beat 0 = LSBs).
REQ-017 FULL, out_valid_o & out_ready_i with idx<Ratio-1: idx increments, stay FULL.
REQ-018 FULL, handshake on idx=Ratio-1: in_ready_o SHALL be 1 combinationally that cycle; if in_valid_i, capture new word, idx=0, stay FULL (no bubble); else go EMPTY.
REQ-019 in_ready_o SHALL be 0 in FULL except per REQ-018; in_ready_o SHALL depend on out_ready_i only, never on in_valid_i.
REQ-020 Latency: word accepted in cycle t -> beat 0 valid in cycle t+1; sustained throughput one beat per cycle, Ratio cycles per word.
REQ-021 out_data_o and idx SHALL remain stable while out_valid_o=1 and out_ready_i=0.
REQ-022 busy_o SHALL equal (state==FULL).
REQ-023 beat_cnt_o SHALL increment by 1 on every out handshake, wrap 0xFFFFFFFF->0; cnt_clr_i clears to 0, clear wins over simultaneous increment.

Reset
REQ-024 During rst_ni=0: state EMPTY, idx=0, out_valid_o=0, busy_o=0, in_ready_o=1, beat_cnt_o=0; held data register SHALL be reset to 0.
REQ-025 Reset asserted mid-word SHALL discard remaining beats; no beat of that word SHALL appear after reset release.

Configuration
REQ-026 Macro SNAX_GEMMX_SER_BEAT_CNT_EN: when defined, beat counter per REQ-023 implemented; when undefined, no counter flops, beat_cnt_o tied to 0, cnt_clr_i ignored; all other behaviour identical.

Verification
REQ-027 Single word 0x..03_02_01_00 pattern (beat k lanes = k), out_ready_i=1 -> beats 0,1,2,3 on cycles t+1..t+4, then out_valid_o=0, busy_o=0.
REQ-028 Back-to-back words W0,W1, in_valid_i always 1, out_ready_i=1 -> 8 consecutive valid beats, no gap; in_ready_o high only on cycles of beat 3.
REQ-029 Backpressure: out_ready_i=0 for 5 cycles during beat 2 -> out_data_o frozen on beat 2, in_ready_o=0, beat 3 follows release.
REQ-030 Reset asserted after beat 1 of W0 -> out_valid_o=0 immediately, next word after release starts at beat 0; no W0 beats emitted.
REQ-031 With SNAX_GEMMX_SER_BEAT_CNT_EN: 3 words -> beat_cnt_o=12; cnt_clr_i pulsed on a handshake cycle -> 0; counter preset near 0xFFFFFFFF wraps to 0; without macro beat_cnt_o stays 0.
